// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//   Per-frame sequencer for the render pipeline:
//     IDLE -> CLEAR (FB/ZB wipe) -> START (geometry kick) -> RENDER (wait for
//     geometry done) -> DRAIN (wait for an idle pipeline) -> WAIT_VS (wait for
//     a vsync rising edge) -> SWAP (flip buffers) -> CLEAR or IDLE.
//
//   Optional build macro: FRAME_SCHED_TIMEOUT_EN
//     Adds a watchdog over RENDER/DRAIN. On expiry it sets the sticky
//     o_timeout flag and forces the frame on to WAIT_VS so it still swaps.
//     Without the macro there is no watchdog and o_timeout is tied low.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_enable           level; keep running frames while high
//   i_vsync            display vsync level (i_clk domain)
//   i_geo_done         pulse: geometry engine emitted its last vertex
//   i_fifo_empty       vertex FIFO empty
//   i_asm_valid        triangle assembler has a triangle in flight
//   i_raster_busy      rasterizer busy
//   o_geo_start        one-cycle geometry start pulse
//   o_clr_active       clear owns the FB/ZB write ports
//   o_clr_addr         clear write address
//   o_clr_fb_we/_pixel framebuffer clear write enable / colour
//   o_clr_zb_we/_data  z-buffer clear write enable / depth
//   o_back_buf         buffer currently being rendered
//   o_swap             one-cycle buffer swap pulse
//   o_busy             scheduler not idle
//   o_frame_count      completed frames (wraps)
//   o_timeout          sticky watchdog flag
// -----------------------------------------------------------------------------
module frame_scheduler #(
  parameter int          FB_PIXELS      = 76800,
  parameter int          ADDR_W         = 17,
  parameter logic [11:0] CLEAR_COLOR    = 12'h000,
  parameter logic [7:0]  CLEAR_Z        = 8'hFF,
  parameter int          DRAIN_CYCLES   = 4,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_vsync,
  input  logic              i_geo_done,
  input  logic              i_fifo_empty,
  input  logic              i_asm_valid,
  input  logic              i_raster_busy,
  output logic              o_geo_start,
  output logic              o_clr_active,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_fb_we,
  output logic [11:0]       o_clr_fb_pixel,
  output logic              o_clr_zb_we,
  output logic [7:0]        o_clr_zb_data,
  output logic              o_back_buf,
  output logic              o_swap,
  output logic              o_busy,
  output logic [15:0]       o_frame_count,
  output logic              o_timeout
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, START, RENDER, DRAIN, WAIT_VS, SWAP
  } state_t;

  localparam int                DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_PIXELS - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              vs_prev;
  logic              back_buf;
  logic [15:0]       frame_cnt;
  logic              pipe_idle;
  logic              vs_rise;
  logic              wd_expire;

  assign pipe_idle = i_fifo_empty & ~i_asm_valid & ~i_raster_busy;
  assign vs_rise   = i_vsync & ~vs_prev;

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int            WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt;
  logic          timeout;

  assign wd_expire = ((state == RENDER) || (state == DRAIN)) && (wd_cnt == WD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == START)                          wd_cnt <= '0;
      else if (state == RENDER || state == DRAIN)  wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) timeout <= 1'b1;
    end
  end

  assign o_timeout = timeout;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_enable) state_nxt = CLEAR;
      CLEAR:   if (addr_cnt == LAST_ADDR) state_nxt = START;
      // geometry may already finish during the start cycle
      START:   state_nxt = i_geo_done ? DRAIN : RENDER;
      RENDER:  if (i_geo_done) state_nxt = DRAIN;
      DRAIN:   if (pipe_idle && drain_cnt == DRAIN_LAST) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_rise) state_nxt = SWAP;
      SWAP:    state_nxt = i_enable ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
    // a stuck frame is pushed on to the swap rather than hanging the display
    if (wd_expire) state_nxt = WAIT_VS;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      drain_cnt <= '0;
      vs_prev   <= 1'b0;
      back_buf  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state   <= state_nxt;
      vs_prev <= i_vsync;
      // address holds 0 everywhere except while sweeping through CLEAR
      addr_cnt  <= (state == CLEAR && state_nxt == CLEAR) ? addr_cnt + 1'b1 : '0;
      // run length of consecutive idle cycles inside DRAIN
      drain_cnt <= (state == DRAIN && state_nxt == DRAIN && pipe_idle) ?
                   drain_cnt + 1'b1 : '0;
      if (state == SWAP) begin
        back_buf  <= ~back_buf;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign o_geo_start    = (state == START);
  assign o_clr_active   = (state == CLEAR);
  assign o_clr_fb_we    = (state == CLEAR);
  assign o_clr_zb_we    = (state == CLEAR);
  assign o_clr_addr     = addr_cnt;
  assign o_clr_fb_pixel = CLEAR_COLOR;
  assign o_clr_zb_data  = CLEAR_Z;
  assign o_swap         = (state == SWAP);
  assign o_busy         = (state != IDLE);
  assign o_back_buf     = back_buf;
  assign o_frame_count  = frame_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//   Directed, table-driven bench for frame_scheduler (FB_PIXELS=16,
//   DRAIN_CYCLES=4, TIMEOUT_CYCLES=50). Each vector is driven at a falling
//   edge and the outputs it produces are compared at the next falling edge.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, vs = 1'b0, gd = 1'b0, fe = 1'b1, av = 1'b0, rb = 1'b0;
  logic        geo_start, clr_active, clr_fb_we, clr_zb_we, back_buf, swap, busy, timeout;
  logic [16:0] clr_addr;
  logic [11:0] clr_fb_pixel;
  logic [7:0]  clr_zb_data;
  logic [15:0] frame_count;

  frame_scheduler #(
    .FB_PIXELS(16), .ADDR_W(17), .CLEAR_COLOR(12'h000), .CLEAR_Z(8'hFF),
    .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_vsync(vs),
    .i_geo_done(gd), .i_fifo_empty(fe), .i_asm_valid(av), .i_raster_busy(rb),
    .o_geo_start(geo_start), .o_clr_active(clr_active), .o_clr_addr(clr_addr),
    .o_clr_fb_we(clr_fb_we), .o_clr_fb_pixel(clr_fb_pixel),
    .o_clr_zb_we(clr_zb_we), .o_clr_zb_data(clr_zb_data),
    .o_back_buf(back_buf), .o_swap(swap), .o_busy(busy),
    .o_frame_count(frame_count), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, gd, fe, av, rb, vs;
    logic        gs, ca;
    logic [16:0] addr;
    logic        sw, busy, bb;
    logic [15:0] fc;
    logic        to;
  } vec_t;

  vec_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        g_bb = 1'b0;
  logic [15:0] g_fc = 16'd0;
  logic        g_to = 1'b0;

  task automatic check(input string nm, input logic e_gs, e_ca, input logic [16:0] e_addr,
                       input logic e_sw, e_busy, e_bb, input logic [15:0] e_fc, input logic e_to);
    n_vec++;
    if (geo_start !== e_gs || clr_active !== e_ca || clr_fb_we !== e_ca || clr_zb_we !== e_ca ||
        clr_addr !== e_addr || clr_fb_pixel !== 12'h000 || clr_zb_data !== 8'hFF ||
        swap !== e_sw || busy !== e_busy || back_buf !== e_bb || frame_count !== e_fc ||
        timeout !== e_to) begin
      n_bad++;
      $display("FAIL %s: got gs=%b ca=%b fbwe=%b zbwe=%b addr=%0d pix=%h z=%h sw=%b busy=%b bb=%b fc=%0d to=%b | want gs=%b ca=%b addr=%0d pix=000 z=ff sw=%b busy=%b bb=%b fc=%0d to=%b",
               nm, geo_start, clr_active, clr_fb_we, clr_zb_we, clr_addr, clr_fb_pixel,
               clr_zb_data, swap, busy, back_buf, frame_count, timeout,
               e_gs, e_ca, e_addr, e_sw, e_busy, e_bb, e_fc, e_to);
    end
  endtask

  task automatic push(input logic i_en, i_gd, i_fe, i_av, i_rb, i_vs,
                      input logic x_gs, x_ca, input int x_addr, input logic x_sw, x_busy);
    vec_t v;
    v.en = i_en; v.gd = i_gd; v.fe = i_fe; v.av = i_av; v.rb = i_rb; v.vs = i_vs;
    v.gs = x_gs; v.ca = x_ca; v.addr = 17'(x_addr); v.sw = x_sw; v.busy = x_busy;
    v.bb = g_bb; v.fc = g_fc; v.to = g_to;
    q.push_back(v);
  endtask

  // busy with nothing else visible (RENDER / DRAIN / WAIT_VS)
  task automatic pb(input logic i_en, i_gd, i_fe, i_av, i_rb, i_vs);
    push(i_en, i_gd, i_fe, i_av, i_rb, i_vs, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  // remaining clear cycles, addresses from..15
  task automatic clears(input logic i_vs, input int from);
    for (int i = from; i < 16; i++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i_vs, 1'b0, 1'b1, i, 1'b0, 1'b1);
  endtask

  task automatic run_q(input string nm);
    for (int i = 0; i < q.size(); i++) begin
      en = q[i].en; gd = q[i].gd; fe = q[i].fe; av = q[i].av; rb = q[i].rb; vs = q[i].vs;
      @(negedge clk);
      check($sformatf("%s[%0d]", nm, i), q[i].gs, q[i].ca, q[i].addr, q[i].sw, q[i].busy,
            q[i].bb, q[i].fc, q[i].to);
    end
    q.delete();
  endtask

  initial begin
    logic [9:0] d_rb, d_av, d_fe;
    d_rb = 10'b0000000101;  // bit d-1: raster busy in drain cycles 1,3
    d_av = 10'b0000000010;  // assembler valid in drain cycle 2
    d_fe = 10'b1111011111;  // fifo not empty in drain cycle 6

    // reset state
    repeat (2) @(negedge clk);
    check("reset", 0, 0, 0, 0, 0, 0, 16'd0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 0, 0, 0, 0, 0, 0, 16'd0, 0);

    // run into RENDER, then reset mid-frame
    push(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    clears(1'b0, 1);
    push(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    pb(1, 0, 1, 0, 0, 0);
    run_q("abort_setup");
    #2 rst_n = 1'b0; en = 1'b0;
    #1 check("abort_async", 0, 0, 0, 0, 0, 0, 16'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_q("abort_idle");

    // frame 1: no stalls, vsync edge 10 cycles after WAIT_VS entry
    push(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    clears(1'b0, 1);
    push(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);   // START
    pb(1, 0, 1, 0, 0, 0);                    // RENDER
    pb(1, 1, 1, 0, 0, 0);                    // geo done -> DRAIN
    repeat (4) pb(1, 0, 1, 0, 0, 0);         // last one enters WAIT_VS
    repeat (9) pb(1, 0, 1, 0, 0, 0);
    push(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);   // SWAP
    g_bb = 1'b1; g_fc = 16'd1;
    push(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1);   // CLEAR restarts
    run_q("frame1");

    // frame 2: stalled drain; vsync toggles so an early WAIT_VS entry would swap early
    clears(1'b0, 1);
    push(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    pb(1, 0, 1, 0, 0, 0);
    pb(1, 1, 1, 0, 0, 0);
    for (int d = 1; d <= 10; d++)
      pb(1, (d == 3), d_fe[d-1], d_av[d-1], d_rb[d-1], (d % 2 == 0));
    pb(1, 1, 1, 0, 0, 0);                    // WAIT_VS, stray geo_done ignored
    push(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);   // SWAP
    g_bb = 1'b0; g_fc = 16'd2;
    push(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
    run_q("frame2");

    // frame 3: geo_done in START, vsync high on entry, enable dropped mid-frame
    clears(1'b1, 1);
    push(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1);   // START
    pb(0, 1, 1, 0, 0, 1);                    // straight to DRAIN
    repeat (4) pb(0, 0, 1, 0, 0, 1);         // -> WAIT_VS with vsync high
    repeat (3) pb(0, 0, 1, 0, 0, 1);         // held high: no swap
    pb(0, 0, 1, 0, 0, 0);                    // falls
    push(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);   // rises -> SWAP
    g_bb = 1'b1; g_fc = 16'd3;
    push(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);   // IDLE
    push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_q("frame3");

    // frame 4: geometry never finishes
    push(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    clears(1'b0, 1);
    push(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    pb(1, 0, 1, 0, 0, 0);
`ifdef FRAME_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 52; k++) begin
      if (k < 50) pb(1, 0, 1, 0, 0, 0);
      else if (k == 50) begin g_to = 1'b1; pb(1, 0, 1, 0, 0, 0); end
      else if (k == 51) begin
        push(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        g_bb = 1'b0; g_fc = 16'd4;
      end else push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end
`else
    for (int k = 1; k <= 60; k++) pb(1, 0, 1, 0, 0, (k % 2 == 1));
`endif
    run_q("frame4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Per-frame controller for the render pipeline. Clears the back framebuffer and z-buffer, pulses the geometry engine start, then waits for geometry completion and full pipeline drain (vertex FIFO, triangle assembler, rasterizer). It then waits for a display vsync edge and swaps front/back buffers. Sits beside geometry_engine/vertex_fifo/triangle_assembler/rasterizer in fpga_top; its o_clr_active drives the top-level FB/ZB write mux.

Parameters:
FB_PIXELS, 76800, number of pixel addresses cleared per frame (320x240)
ADDR_W, 17, framebuffer/z-buffer address width
CLEAR_COLOR, 12'h000, colour written during clear
CLEAR_Z, 8'hFF, depth written during clear (far plane)
DRAIN_CYCLES, 4, consecutive idle cycles needed to declare the pipeline drained
TIMEOUT_CYCLES, 2_000_000, watchdog limit (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  level; run frames continuously while high
i_vsync  in  1  display vsync level, synchronous to i_clk
i_geo_done  in  1  one-cycle pulse: geometry engine emitted its last vertex
i_fifo_empty  in  1  vertex_fifo empty
i_asm_valid  in  1  triangle_assembler o_tri_valid
i_raster_busy  in  1  rasterizer o_busy
o_geo_start  out  1  one-cycle start pulse to the geometry engine
o_clr_active  out  1  high while clear owns the FB/ZB write ports
o_clr_addr  out  ADDR_W  clear write address
o_clr_fb_we  out  1  framebuffer clear write enable
o_clr_fb_pixel  out  12  equals CLEAR_COLOR
o_clr_zb_we  out  1  z-buffer clear write enable
o_clr_zb_data  out  8  equals CLEAR_Z
o_back_buf  out  1  index of the buffer currently being rendered
o_swap  out  1  one-cycle pulse when the buffers swap
o_busy  out  1  state != IDLE
o_frame_count  out  16  completed frames, wraps at 16'hFFFF->0
o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0 except o_clr_fb_pixel=CLEAR_COLOR and o_clr_zb_data=CLEAR_Z (constants); counters 0; vsync edge register 0. Reset asserted mid-frame aborts immediately, with no swap.
- IDLE: if i_enable=1 -> CLEAR next cycle; address counter set to 0.
- CLEAR: o_clr_active=o_clr_fb_we=o_clr_zb_we=1; o_clr_addr = counter; counter increments every cycle. At counter=FB_PIXELS-1 -> START. Exactly FB_PIXELS writes, addresses 0..FB_PIXELS-1. o_clr_addr returns to 0 when CLEAR exits.
- START: o_geo_start=1 for exactly this cycle -> RENDER.
- RENDER: wait for i_geo_done -> DRAIN. i_geo_done is sampled in START and RENDER; a pulse in START moves to DRAIN on the following cycle. Pulses in any other state are ignored.
- DRAIN: idle = i_fifo_empty & !i_asm_valid & !i_raster_busy. Idle counter increments on idle cycles and clears to 0 on any non-idle cycle. When the counter reaches DRAIN_CYCLES -> WAIT_VS.
- WAIT_VS: rising edge of i_vsync (current=1, previous sample=0) -> SWAP. A vsync already high on entry does not count. The edge register samples every cycle in every state.
- SWAP: o_swap=1 for one cycle; o_back_buf toggles; o_frame_count increments. Next state is CLEAR if i_enable=1, else IDLE.
- Dropping i_enable mid-frame has no effect until SWAP; the current frame always completes.
- o_busy is a registered/decoded state != IDLE. No output toggles in the same cycle as the input that causes it; all decisions are registered, one cycle per transition.
- Frame latency with no stalls = 1 (IDLE) + FB_PIXELS + 1 + render + DRAIN_CYCLES + vsync wait + 1.

Optional Feature:
FRAME_SCHED_TIMEOUT_EN
- Defined: a watchdog counter runs in RENDER and DRAIN and clears on entry to START. When it reaches TIMEOUT_CYCLES, o_timeout is set (sticky until reset) and the state forces to WAIT_VS; the frame still swaps.
- Not defined: no counter; o_timeout tied to 0; RENDER/DRAIN wait indefinitely.

Test Plan:
FB_PIXELS=16, DRAIN_CYCLES=4: reset, i_enable=1 -> o_clr_fb_we/o_clr_zb_we high 16 consecutive cycles, addr 0..15, pixel 12'h000, z 8'hFF; then o_geo_start single pulse.
i_geo_done one cycle after start, pipeline idle, vsync edge 10 cycles later -> o_swap one cycle, o_back_buf 0->1, o_frame_count=1, CLEAR restarts.
DRAIN with i_raster_busy high for 3 cycles, idle 2, busy 1, idle 4 -> WAIT_VS entered only after the final 4 idle cycles.
i_vsync held high on WAIT_VS entry -> no swap until vsync falls and rises again.
i_rst_n low in RENDER -> immediate IDLE, outputs 0, o_frame_count unchanged at 0; i_enable=0 at SWAP -> IDLE, o_busy=0.
With FRAME_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, i_geo_done never asserted -> o_timeout=1 after 50 cycles in RENDER, swap on next vsync edge; without macro -> o_timeout=0, state stays RENDER.
